ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 device-to-host serial receiver. Synchronizes and deglitches the raw keyboard `ps2_clk`/`ps2_data` lines and deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Emits each valid scan-code byte with a one-cycle strobe; this is the `new_in`/`in[7:0]` source for the scan-code-to-ASCII stage. Malformed or stalled frames are dropped and flagged.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on each raw line (≥2).
- `FILTER_LEN`, 4: consecutive equal synchronized samples required before the filtered clock changes.
- `TIMEOUT`, 10000: cycles without a filtered-clock fall before a partial frame is abandoned (200 µs at 50 MHz).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous, idle high.
- `ps2_data`  in  1  raw PS/2 data, asynchronous, idle high.
- `out`  out  8  last valid received byte; feeds `in` of the ASCII stage.
- `new_out`  out  1  one-cycle strobe: `out` updated this cycle; feeds `new_in`.
- `err`  out  1  one-cycle strobe: frame dropped (parity, stop, or timeout).

## Operation
- Sync: each raw line passes through `SYNC_STAGES` flops, reset to 1.
- Filter: `fclk` (reset 1) takes the synchronized clock value once the last `FILTER_LEN` synchronized samples all equal it. Pulses shorter than `FILTER_LEN` cycles never reach `fclk`.
- `fall` = previous `fclk` is 1 and current `fclk` is 0. Synchronized `ps2_data` is sampled only in a `fall` cycle.
- FSM states:
  - IDLE:
    - `fall` with data 0 → DATA; bit count 0.
    - `fall` with data 1 → stay in IDLE; no error.
  - DATA: each `fall` shifts data into shift-register bit 7 (right shift, LSB first). After the 8th bit → PARITY.
  - PARITY: next `fall` captures the parity bit → STOP.
  - STOP: next `fall` → IDLE.
    - If stop = 1 and the XOR of the 8 data bits and parity = 1 (odd): `out` ← shift register and `new_out` pulses.
    - Otherwise `err` pulses and `out` is unchanged.
- Timeout:
  - The counter clears on every `fall` and in IDLE, and increments in DATA/PARITY/STOP.
  - When it reaches `TIMEOUT-1`: → IDLE, `err` pulses, shift register is discarded.
  - Counter width is `$clog2(TIMEOUT)`; it must not wrap.
- `new_out` and `err` are never high together. Both are low in every cycle without a completed or abandoned frame.
- `out` holds its value between frames. It changes only on a valid frame.

## Timing
- Reset values: `out`=0x00, `new_out`=0, `err`=0, state IDLE, `fclk`=1, sync flops=1, filter history=1, counters=0.
- `rst` mid-frame returns to IDLE with no strobe. The next complete frame after `rst` deasserts is received normally.
- Each strobe is registered: it goes high the cycle after the `fall` that ends the frame (or the cycle after the timeout count is reached) and stays high exactly 1 cycle.
- Latency from a clean raw `ps2_clk` fall to `fclk` fall is `SYNC_STAGES`+`FILTER_LEN` cycles, ±1 for sampling phase. The strobe follows 1 cycle later.
- Back-to-back frames need no idle gap beyond the stop bit. A new start bit may follow the stop bit immediately.
- `ps2_data` held low in IDLE with no clock activity causes no action.

## Test plan
PS/2 half-period is 2000 cycles in all frames below.
- Valid byte 0x1C (data 0,0,1,1,1,0,0,0, parity 0, stop 1) → `out`=0x1C, `new_out` high for exactly 1 cycle, `err` stays 0.
- Back-to-back 0xF0 (parity 1) then 0x1C (parity 0), no gap → two `new_out` pulses with `out`=0xF0 then 0x1C.
- 0x1C with parity 1 → `err` pulses once, no `new_out`, `out` keeps its previous value. A following valid 0x5A (parity 1) → `out`=0x5A, `new_out` pulses.
- Stop bit 0 on 0x76 → `err` pulse, `out` unchanged.
- Start bit plus 3 data bits, then clock held high → `err` pulses `TIMEOUT` cycles (±`FILTER_LEN`+3) after the last fall. A following valid 0x29 is received.
- Glitches:
  - 2-cycle low pulses on `ps2_clk` (< `FILTER_LEN`) injected mid-bit during a 0x45 frame → `out`=0x45, no `err`.
  - `rst` asserted for 1 cycle after the 4th data bit → no strobes, and the next 0x16 frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_if.sv
// PS/2 receiver boundary: raw keyboard lines in, scan-code byte stream out.
// master = receiver side, slave = line driver / byte consumer side.
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] out;
  logic       new_out;
  logic       err;

  modport master (input ps2_clk, ps2_data, output out, new_out, err);
  modport slave  (output ps2_clk, ps2_data, input out, new_out, err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync + deglitch raw lines, deserialize 11-bit frames.
// Valid bytes emit a one-cycle new_out strobe; bad or stalled frames emit a one-cycle err strobe.
module ps2_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT     = 10000
) (
  input  logic     clk,
  input  logic     rst,
  ps2_rx_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_TOP = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [FILTER_LEN-2:0]  hist_q, hist_d;
  logic [FILTER_LEN-1:0]  window;
  logic                   fclk_q, fclk_d, fclk_prev_q, fclk_prev_d;
  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             out_q, out_d;
  logic                   new_out_q, new_out_d, err_q, err_d;
  logic                   clk_s, dat_s, fall;

  // Window includes the current synchronized sample, so fclk moves FILTER_LEN cycles after the line settles.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
    clk_s       = clk_sync_q[SYNC_STAGES-1];
    dat_s       = dat_sync_q[SYNC_STAGES-1];
    window      = {hist_q, clk_s};
    hist_d      = window[FILTER_LEN-2:0];
    fclk_d      = fclk_q;
    if (&window)
      fclk_d = 1'b1;
    else if (~|window)
      fclk_d = 1'b0;
    fclk_prev_d = fclk_q;
    fall        = fclk_prev_q & ~fclk_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    new_out_d = 1'b0;
    err_d     = 1'b0;

    // Stall watchdog: saturates at CNT_TOP and abandons the frame, so it never wraps.
    if (state_q == IDLE || fall) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TOP) begin
      cnt_d   = '0;
      state_d = IDLE;
      shift_d = '0;
      err_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7)
            state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s && (^{shift_q, par_q})) begin
            out_d     = shift_q;
            new_out_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      hist_q      <= '1;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      new_out_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      hist_q      <= hist_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      new_out_q   <= new_out_d;
      err_q       <= err_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.new_out = new_out_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: fixed frame table, hand-built corner sequences, and random frames vs a byte-level model.
module tb_ps2_rx;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TMO  = 400;
  localparam int H    = 20;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   nstb = 0, nerr = 0, both_cnt = 0, err_cyc = 0, last_fall = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_out;

  ps2_rx_if bus ();
  ps2_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.new_out) begin
        nstb++;
        got_q.push_back(bus.out);
      end
      if (bus.err) begin
        nerr++;
        err_cyc = cyc;
      end
      if (bus.new_out && bus.err) both_cnt++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Drives nbits of a start/data/parity/stop frame; data changes while clock is high.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit glitch, input int nbits, input bit rst_after4);
    logic [10:0] b;
    b = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = b[i];
      if (glitch) begin
        wait_cyc(H/2 - 2);
        bus.ps2_clk = 1'b0;
        wait_cyc(2);
        bus.ps2_clk = 1'b1;
        wait_cyc(H/2);
      end else begin
        wait_cyc(H);
      end
      bus.ps2_clk = 1'b0;
      last_fall = cyc;
      wait_cyc(H);
      bus.ps2_clk = 1'b1;
      if (rst_after4 && i == 4) begin
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
      end
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic par,
                           input logic stp, input bit glitch, input bit exp_new, input bit exp_err);
    int s0, e0;
    logic [7:0] g;
    got_q.delete();
    s0 = nstb;
    e0 = nerr;
    send_frame(d, par, stp, glitch, 11, 1'b0);
    wait_cyc(10);
    check({name, "_new_cnt"}, nstb - s0, 32'(exp_new));
    check({name, "_err_cnt"}, nerr - e0, 32'(exp_err));
    if (exp_new) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check({name, "_strobe_out"}, g, d);
      exp_out = d;
    end
    check({name, "_out"}, bus.out, exp_out);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stp;
    bit         glitch;
    bit         exp_new;
    bit         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s0, e0, lat;
    logic [7:0] d;
    logic par, stp, en, ee;
    bit gl;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h76, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h45, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    exp_out = 8'h00;
    wait_cyc(5);
    check("reset_out", bus.out, 8'h00);
    check("reset_new_out", bus.new_out, 1'b0);
    check("reset_err", bus.err, 1'b0);
    rst = 1'b0;
    wait_cyc(5);

    // Data held low in IDLE without clock activity must do nothing.
    bus.ps2_data = 1'b0;
    wait_cyc(50);
    bus.ps2_data = 1'b1;
    check("idle_low_data_strobes", nstb + nerr, 0);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].par, vecs[i].stp,
                vecs[i].glitch, vecs[i].exp_new, vecs[i].exp_err);

    got_q.delete();
    s0 = nstb;
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11, 1'b0);
    wait_cyc(10);
    check("b2b_count", nstb - s0, 2);
    check("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hF0);
    check("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'h1C);
    exp_out = 8'h1C;

    s0 = nstb;
    e0 = nerr;
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    wait_cyc(TMO + 40);
    lat = err_cyc - last_fall;
    check("timeout_err_cnt", nerr - e0, 1);
    check("timeout_new_cnt", nstb - s0, 0);
    check("timeout_latency_ok", (lat >= TMO && lat <= TMO + SYNC + FILT + 3) ? 1 : 0, 1);
    check("timeout_out", bus.out, exp_out);
    run_frame("after_timeout", 8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // 0xF0 keeps data high after bit 4, so no stray start bit follows the reset.
    s0 = nstb;
    e0 = nerr;
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 11, 1'b1);
    wait_cyc(10);
    check("rst_mid_strobes", (nstb - s0) + (nerr - e0), 0);
    exp_out = 8'h00;
    check("rst_mid_out", bus.out, exp_out);
    run_frame("after_rst", 8'h16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Random frames: a frame is valid exactly when stop is 1 and data+parity has odd weight.
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom);
      par = ~^d;
      if ($urandom_range(3) == 0) par = ~par;
      stp = ($urandom_range(7) != 0);
      gl  = ($urandom_range(2) == 0);
      en  = stp && ((($countones(d) + int'(par)) % 2) == 1);
      ee  = !en;
      run_frame($sformatf("rnd%0d", i), d, par, stp, gl, en, ee);
    end

    check("never_both_high", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
